// File: rtl/ccff_bitstream_loader.sv
// Word-to-serial loader driving the head of a CCFF configuration chain, MSB first.
// Optional readback of the chain tail is enabled by defining CCFF_TAIL_CAPTURE_EN.
module ccff_bitstream_loader #(
  parameter int DATA_W    = 8,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              config_enable,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count,
  output logic [DATA_W-1:0] tail_word
);

  localparam int LEFT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [LEFT_W-1:0] r_bitsLeft;
  logic [CNT_W-1:0]  r_bitCount;
  logic              r_busy;
  logic              r_done;
  logic              r_ready;
  logic              r_enable;
  logic              w_lastBit;
  logic              w_startAccept;

  assign w_lastBit     = (r_bitCount == CNT_W'(CHAIN_LEN - 1));
  assign w_startAccept = (r_state == IDLE) && start;

  // Chain length limit wins over word boundaries, so a partial final word is dropped.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_bitsLeft <= '0;
      r_bitCount <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ready    <= 1'b0;
      r_enable   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= LOAD;
            r_bitCount <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
            r_ready    <= 1'b1;
          end
        end
        LOAD: begin
          if (s_valid) begin
            r_shreg    <= s_data;
            r_bitsLeft <= LEFT_W'(DATA_W);
            r_state    <= SHIFT;
            r_ready    <= 1'b0;
            r_enable   <= 1'b1;
          end
        end
        SHIFT: begin
          r_shreg    <= r_shreg << 1;
          r_bitsLeft <= r_bitsLeft - LEFT_W'(1);
          r_bitCount <= r_bitCount + CNT_W'(1);
          if (w_lastBit) begin
            r_state  <= DONE;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else if (r_bitsLeft == LEFT_W'(1)) begin
            r_state  <= LOAD;
            r_enable <= 1'b0;
            r_ready  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign s_ready       = r_ready;
  assign config_enable = r_enable;
  assign ccff_head     = r_enable & r_shreg[DATA_W-1];
  assign busy          = r_busy;
  assign done          = r_done;
  assign bit_count     = r_bitCount;

`ifdef CCFF_TAIL_CAPTURE_EN
  logic [DATA_W-1:0] r_tailWord;

  // Bits leaving the chain are the old configuration, giving readback for free.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_tailWord <= '0;
    end else if (w_startAccept) begin
      r_tailWord <= '0;
    end else if (r_enable) begin
      r_tailWord <= {r_tailWord[DATA_W-2:0], ccff_tail};
    end
  end

  assign tail_word = r_tailWord;
`else
  logic w_unusedTail;
  logic w_unusedStart;

  assign w_unusedTail  = ccff_tail;
  assign w_unusedStart = w_startAccept;
  assign tail_word     = '0;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Self-checking bench: two loaders (16-bit and 12-bit chains) against a bit-stream
// model and a behavioural model of the configuration chain itself.
module tb_ccff_bitstream_loader;

  logic clk = 1'b0;
  logic rstN;

  always #5 clk = ~clk;

  logic        start0, valid0, ready0, head0, en0, busy0, done0;
  logic [7:0]  data0, tw0;
  logic [4:0]  cnt0;
  logic        start1, valid1, ready1, head1, en1, busy1, done1;
  logic [7:0]  data1, tw1;
  logic [3:0]  cnt1;

  logic [15:0] chain0;
  logic [11:0] chain1;
  logic        preReq0, preReq1;
  logic [15:0] preVal0;
  logic [11:0] preVal1;

  logic [31:0] str0 = '0, str1 = '0;
  int          enCnt0 = 0, enCnt1 = 0, hs0 = 0, hs1 = 0, badCnt = 0;

  int checks = 0;
  int errors = 0;

  ccff_bitstream_loader #(.DATA_W(8), .CHAIN_LEN(16)) dut0 (
    .prog_clk(clk), .pReset_n(rstN), .start(start0), .s_data(data0), .s_valid(valid0),
    .s_ready(ready0), .ccff_head(head0), .config_enable(en0), .ccff_tail(chain0[15]),
    .busy(busy0), .done(done0), .bit_count(cnt0), .tail_word(tw0)
  );

  ccff_bitstream_loader #(.DATA_W(8), .CHAIN_LEN(12)) dut1 (
    .prog_clk(clk), .pReset_n(rstN), .start(start1), .s_data(data1), .s_valid(valid1),
    .s_ready(ready1), .ccff_head(head1), .config_enable(en1), .ccff_tail(chain1[11]),
    .busy(busy1), .done(done1), .bit_count(cnt1), .tail_word(tw1)
  );

  // Behavioural chains: shift on enabled edges, untouched by the loader's reset.
  always @(posedge clk) begin
    if (preReq0) chain0 <= preVal0;
    else if (en0) chain0 <= {chain0[14:0], head0};
    if (preReq1) chain1 <= preVal1;
    else if (en1) chain1 <= {chain1[10:0], head1};
  end

  // Observe the serial stream, handshakes and protocol violations mid-cycle.
  always @(negedge clk) begin
    if (en0) begin str0 <= {str0[30:0], head0}; enCnt0 <= enCnt0 + 1; end
    if (en1) begin str1 <= {str1[30:0], head1}; enCnt1 <= enCnt1 + 1; end
    if (valid0 && ready0) hs0 <= hs0 + 1;
    if (valid1 && ready1) hs1 <= hs1 + 1;
    if ((!en0 && head0) || (!en1 && head1) || (ready0 && en0) || (ready1 && en1))
      badCnt <= badCnt + 1;
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic setStart(int k, logic v);
    if (k == 0) start0 = v; else start1 = v;
  endtask

  task automatic setValid(int k, logic v, logic [7:0] d);
    if (k == 0) begin valid0 = v; data0 = d; end
    else begin valid1 = v; data1 = d; end
  endtask

  task automatic preload(int k, logic [15:0] v);
    if (k == 0) begin preReq0 = 1'b1; preVal0 = v; end
    else begin preReq1 = 1'b1; preVal1 = v[11:0]; end
    @(posedge clk);
    #1;
    preReq0 = 1'b0;
    preReq1 = 1'b0;
  endtask

  function automatic logic getReady(int k); return (k == 0) ? ready0 : ready1; endfunction
  function automatic logic getDone(int k);  return (k == 0) ? done0 : done1;   endfunction
  function automatic logic getBusy(int k);  return (k == 0) ? busy0 : busy1;   endfunction
  function automatic logic getEn(int k);    return (k == 0) ? en0 : en1;       endfunction
  function automatic int   getEnCnt(int k); return (k == 0) ? enCnt0 : enCnt1; endfunction
  function automatic int   getHs(int k);    return (k == 0) ? hs0 : hs1;       endfunction
  function automatic logic [31:0] getCnt(int k);
    return (k == 0) ? 32'(cnt0) : 32'(cnt1);
  endfunction
  function automatic logic [31:0] getTail(int k);
    return (k == 0) ? 32'(tw0) : 32'(tw1);
  endfunction
  function automatic logic [31:0] getStream(int k);
    return (k == 0) ? str0 : str1;
  endfunction
  function automatic logic [15:0] getChain(int k);
    return (k == 0) ? chain0 : {4'b0, chain1};
  endfunction

  // One complete load of two words; gaps are idle LOAD cycles before each word.
  task automatic runLoad(int k, logic [7:0] wa, logic [7:0] wb, int ga, int gb, string tag);
    int          len;
    int          enBase, hsBase;
    logic [15:0] chainBefore, expStream;
    logic [31:0] mask, expTail;
    logic [7:0]  w[2];
    int          g[2];
    logic        accepted, gotDone;
    len         = (k == 0) ? 16 : 12;
    chainBefore = getChain(k);
    expStream   = {wa, wb} >> (16 - len);
    mask        = (32'd1 << len) - 32'd1;
`ifdef CCFF_TAIL_CAPTURE_EN
    expTail = 32'(chainBefore[7:0]);
`else
    expTail = 32'd0;
`endif
    enBase = getEnCnt(k);
    hsBase = getHs(k);
    w[0] = wa; w[1] = wb; g[0] = ga; g[1] = gb;
    setStart(k, 1'b1);
    @(posedge clk);
    #1;
    setStart(k, 1'b0);
    for (int i = 0; i < 2; i++) begin
      accepted = 1'b0;
      if (g[i] == 0) setValid(k, 1'b1, w[i]);
      for (int c = 0; c < 64 && !accepted; c++) begin
        sample();
        if (i == 0 && c == 0) begin
          check({tag, " ready after start"}, 32'({getReady(k), getBusy(k), getEn(k)}), 32'b110);
        end
        if (getReady(k)) begin
          if (g[i] != 0) begin
            repeat (g[i]) begin
              @(posedge clk);
              #1;
            end
            setValid(k, 1'b1, w[i]);
          end
          @(posedge clk);
          #1;
          accepted = 1'b1;
        end
      end
      check({tag, " word accepted"}, 32'(accepted), 32'd1);
      setValid(k, 1'b0, 8'h00);
    end
    setValid(k, 1'b1, 8'($urandom));
    gotDone = 1'b0;
    for (int c = 0; c < 200 && !gotDone; c++) begin
      sample();
      gotDone = getDone(k);
    end
    check({tag, " done reached"}, 32'(gotDone), 32'd1);
    check({tag, " busy/ready at done"}, 32'({getBusy(k), getReady(k)}), 32'd0);
    check({tag, " bit_count"}, getCnt(k), 32'(len));
    check({tag, " enable cycles"}, 32'(getEnCnt(k) - enBase), 32'(len));
    check({tag, " handshakes"}, 32'(getHs(k) - hsBase), 32'd2);
    check({tag, " head stream"}, getStream(k) & mask, 32'(expStream));
    repeat (2) sample();
    setValid(k, 1'b0, 8'h00);
    check({tag, " done sticky"}, 32'({getDone(k), getBusy(k), getReady(k)}), 32'b100);
    check({tag, " count held"}, getCnt(k), 32'(len));
    check({tag, " chain contents"}, 32'(getChain(k)), 32'(expStream));
    check({tag, " tail_word"}, getTail(k), expTail);
  endtask

  initial begin
    int enBase;
    logic reached;
    rstN   = 1'b0;
    start0 = 1'b0; valid0 = 1'b0; data0 = 8'h00;
    start1 = 1'b0; valid1 = 1'b0; data1 = 8'h00;
    preReq0 = 1'b0; preReq1 = 1'b0; preVal0 = '0; preVal1 = '0;
    repeat (2) sample();
    check("reset outputs 0", 32'({ready0, head0, en0, busy0, done0}), 32'd0);
    check("reset count/tail 0", {cnt0, tw0, cnt1, tw1}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    preload(0, 16'hFFFF);
    runLoad(0, 8'h00, 8'h00, 0, 0, "tail");
    runLoad(0, 8'hA5, 8'h3C, 0, 0, "basic");
    runLoad(0, 8'hA5, 8'h3C, 0, 3, "backpressure");
    preload(1, 16'h0ABC);
    runLoad(1, 8'hA5, 8'h3C, 0, 0, "trunc");

    // Ignored start during SHIFT, then an asynchronous reset after 5 shifted bits.
    setStart(0, 1'b1);
    @(posedge clk);
    #1;
    setStart(0, 1'b0);
    setValid(0, 1'b1, 8'($urandom));
    enBase  = enCnt0;
    reached = 1'b0;
    for (int c = 0; c < 50 && !reached; c++) begin
      sample();
      reached = (enCnt0 - enBase) >= 3;
    end
    setStart(0, 1'b1);
    @(posedge clk);
    #1;
    setStart(0, 1'b0);
    for (int c = 0; c < 50 && (enCnt0 - enBase) < 5; c++) sample();
    @(posedge clk);
    #2;
    check("start ignored count", 32'(cnt0), 32'd5);
    check("start ignored busy", 32'({busy0, en0}), 32'b11);
    rstN = 1'b0;
    #1;
    check("mid-shift reset outputs", 32'({ready0, head0, en0, busy0, done0}), 32'd0);
    check("mid-shift reset count/tail", 32'({cnt0, tw0}), 32'd0);
    setValid(0, 1'b0, 8'h00);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    runLoad(0, 8'hFF, 8'h00, 0, 0, "reload");

    for (int n = 0; n < 6; n++) begin
      runLoad(n % 2, 8'($urandom), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), "random");
    end

    check("protocol violations", 32'(badCnt), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
